// File: rtl/final_soc_nios2_gen2_o_cpu_debug_pkg.sv
// Shared types and constants for the Nios II debug-slave JTAG host driver.
package final_soc_nios2_gen2_o_cpu_debug_pkg;

  localparam int unsigned DEBUG_SR_WIDTH = 38;
  localparam int unsigned DEBUG_IR_WIDTH = 2;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    RESP
  } dbg_state_e;

endpackage

// File: rtl/final_soc_nios2_gen2_o_cpu_debug_host_tckgen.sv
// Divided JTAG clock: TCK_DIV clk low then TCK_DIV clk high, with one-cycle
// enables on the clk edges where tck rises and falls.
module final_soc_nios2_gen2_o_cpu_debug_host_tckgen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic tck_rise_en,
  output logic tck_fall_en
);

  localparam int unsigned CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          last;

  assign last = (cnt_q == CW'(TCK_DIV - 1));

  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (run) begin
      if (last) begin
        cnt_d = '0;
        tck_d = ~tck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
        tck_d = tck_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck         = tck_q;
  assign tck_rise_en = run & last & ~tck_q;
  assign tck_fall_en = run & last & tck_q;

endmodule

// File: rtl/final_soc_nios2_gen2_o_cpu_debug_jtag_host.sv
// Host-side virtual-JTAG driver for the Nios II debug slave: runs one IR
// update and optional DR scan per command and returns the captured bits.
module final_soc_nios2_gen2_o_cpu_debug_jtag_host
  import final_soc_nios2_gen2_o_cpu_debug_pkg::*;
#(
  parameter int unsigned SR_WIDTH = DEBUG_SR_WIDTH,
  parameter int unsigned IR_WIDTH = DEBUG_IR_WIDTH,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                busy,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned BW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

  dbg_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                ir_only_q, ir_only_d;
  logic [SR_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                tdi_q, tdi_d;
  logic [SR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0] rsp_ir_out_q, rsp_ir_out_d;

  logic run, tck_rise_en, tck_fall_en;

  assign run = (state_q != IDLE) && (state_q != RESP);

  final_soc_nios2_gen2_o_cpu_debug_host_tckgen #(
    .TCK_DIV(TCK_DIV)
  ) u_tckgen (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .tck         (vji_tck),
    .tck_rise_en (tck_rise_en),
    .tck_fall_en (tck_fall_en)
  );

  // Samples happen on the rise enable; every state/tdi change is on the fall
  // enable so the slave only sees changes at the start of a low phase.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    ir_only_d    = ir_only_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    tdi_d        = tdi_q;
    rsp_data_d   = rsp_data_q;
    rsp_ir_out_d = rsp_ir_out_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ir_d      = cmd_ir;
          shift_d   = cmd_data;
          ir_only_d = cmd_ir_only;
          bit_cnt_d = '0;
          state_d   = UIR;
        end
      end
      UIR: begin
        if (tck_rise_en) rsp_ir_out_d = vji_ir_out;
        if (tck_fall_en) state_d = ir_only_q ? RTI : CDR;
      end
      CDR: begin
        if (tck_fall_en) begin
          state_d   = SDR;
          tdi_d     = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      SDR: begin
        if (tck_rise_en) shift_d = {vji_tdo, shift_q[SR_WIDTH-1:1]};
        if (tck_fall_en) begin
          if (bit_cnt_q == BW'(SR_WIDTH - 1)) begin
            state_d = UDR;
            tdi_d   = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tdi_d     = shift_q[0];
          end
        end
      end
      UDR: begin
        if (tck_fall_en) state_d = RTI;
      end
      RTI: begin
        if (tck_fall_en) begin
          state_d    = RESP;
          rsp_data_d = ir_only_q ? '0 : shift_q;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ir_q         <= '0;
      ir_only_q    <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      tdi_q        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ir_out_q <= '0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_only_q    <= ir_only_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      tdi_q        <= tdi_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ir_out_q <= rsp_ir_out_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_data   = rsp_data_q;
  assign rsp_ir_out = rsp_ir_out_q;
  assign vji_tdi    = tdi_q;
  assign vji_ir_in  = ir_q;
  assign vji_uir    = (state_q == UIR);
  assign vji_cdr    = (state_q == CDR);
  assign vji_sdr    = (state_q == SDR);
  assign vji_udr    = (state_q == UDR);
  assign vji_rti    = (state_q == IDLE) || (state_q == RTI) || (state_q == RESP);

endmodule

// File: tb/tb_final_soc_nios2_gen2_o_cpu_debug_jtag_host.sv
// Directed bench for the debug JTAG host: two instances (TCK_DIV=2 and 1),
// each looped through a 38-bit slave shift-register model.
module tb_final_soc_nios2_gen2_o_cpu_debug_jtag_host;
  import final_soc_nios2_gen2_o_cpu_debug_pkg::*;

  localparam int unsigned W  = 38;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, rsp_ready, cmd_ir_only;
  logic [IW-1:0] cmd_ir, ir_out;
  logic [W-1:0]  cmd_data;

  logic cmd_valid, cmd_ready, rsp_valid, busy, tck, tdi, tdo, uir, cdr, sdr, udr, rti;
  logic [W-1:0]  rsp_data;
  logic [IW-1:0] rsp_ir_out, ir_in;

  logic cmd_valid_b, cmd_ready_b, rsp_valid_b, busy_b, tck_b, tdi_b, tdo_b;
  logic uir_b, cdr_b, sdr_b, udr_b, rti_b;
  logic [W-1:0]  rsp_data_b;
  logic [IW-1:0] rsp_ir_out_b, ir_in_b;

  int checks = 0;
  int errors = 0;

  final_soc_nios2_gen2_o_cpu_debug_jtag_host #(.SR_WIDTH(W), .IR_WIDTH(IW), .TCK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_ir_only(cmd_ir_only),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ir_out(rsp_ir_out), .busy(busy), .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo),
    .vji_ir_in(ir_in), .vji_ir_out(ir_out), .vji_uir(uir), .vji_cdr(cdr),
    .vji_sdr(sdr), .vji_udr(udr), .vji_rti(rti));

  final_soc_nios2_gen2_o_cpu_debug_jtag_host #(.SR_WIDTH(W), .IR_WIDTH(IW), .TCK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .cmd_ir_only(cmd_ir_only),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b),
    .rsp_ir_out(rsp_ir_out_b), .busy(busy_b), .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b),
    .vji_ir_in(ir_in_b), .vji_ir_out(ir_out), .vji_uir(uir_b), .vji_cdr(cdr_b),
    .vji_sdr(sdr_b), .vji_udr(udr_b), .vji_rti(rti_b));

  // Slave models: shift on tck rise during SDR, count strobe periods.
  logic         load_a = 1'b0, load_b = 1'b0;
  logic [W-1:0] preload, model_a, model_b;
  logic [IW-1:0] uir_ir_a;
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_sdr_b = 0;

  assign tdo   = model_a[0];
  assign tdo_b = model_b[0];

  always @(posedge tck or posedge load_a) begin
    if (load_a) model_a <= preload;
    else begin
      if (sdr) model_a <= {tdi, model_a[W-1:1]};
      if (uir) begin n_uir <= n_uir + 1; uir_ir_a <= ir_in; end
      if (cdr) n_cdr <= n_cdr + 1;
      if (sdr) n_sdr <= n_sdr + 1;
      if (udr) n_udr <= n_udr + 1;
    end
  end

  always @(posedge tck_b or posedge load_b) begin
    if (load_b) model_b <= preload;
    else if (sdr_b) begin
      model_b <= {tdi_b, model_b[W-1:1]};
      n_sdr_b <= n_sdr_b + 1;
    end
  end

  task automatic load_model_a(input logic [W-1:0] v);
    preload = v; #1 load_a = 1'b1; #1 load_a = 1'b0;
  endtask

  // Issue one command to dut; lat counts clk edges from accept to rsp_valid.
  task automatic run_a(input logic [IW-1:0] ir, input logic [W-1:0] d, input logic only,
                       output int lat);
    @(negedge clk);
    cmd_ir = ir; cmd_data = d; cmd_ir_only = only; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 1000) begin @(posedge clk); #1 lat++; end
  endtask

  task automatic consume_a;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    int lat;
    reset_n = 1'b0;
    #1;
    checks++; if (rti !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL por_state: rti=%b cmd_ready=%b busy=%b, want 1 1 0", rti, cmd_ready, busy); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // Leave nonzero response registers behind, then abort a scan at a random point.
    ir_out = 2'b11;
    load_model_a(38'h3F_1234_5678);
    run_a(IR_TRACECTRL, 38'h01_0F0F_0F0F, 1'b0, lat);
    consume_a();
    @(negedge clk);
    cmd_ir = IR_TRACECTRL; cmd_data = 38'h3A_AAAA_5555; cmd_ir_only = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat ($urandom_range(10, 150)) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++; if ({cmd_ready, rsp_valid, busy, tck, tdi} !== 5'b10000) begin errors++;
      $display("FAIL reset_ctrl: {rdy,vld,busy,tck,tdi}=%b want 10000", {cmd_ready, rsp_valid, busy, tck, tdi}); end
    checks++; if (rsp_data !== '0 || rsp_ir_out !== '0 || ir_in !== '0) begin errors++;
      $display("FAIL reset_regs: data=%h irout=%b irin=%b want 0", rsp_data, rsp_ir_out, ir_in); end
    checks++; if ({uir, cdr, sdr, udr, rti} !== 5'b00001) begin errors++;
      $display("FAIL reset_strobes: %b want 00001", {uir, cdr, sdr, udr, rti}); end
    @(negedge clk); reset_n = 1'b1;
    ir_out = 2'b00;
  endtask

  task automatic test_full_scan(input string tag);
    int lat, s_uir, s_cdr, s_sdr, s_udr;
    load_model_a(38'h15_DEAD_BEEF);
    s_uir = n_uir; s_cdr = n_cdr; s_sdr = n_sdr; s_udr = n_udr;
    run_a(IR_OCIMEM, 38'h2A_5555_AAAA, 1'b0, lat);
    checks++; if (lat !== 168) begin errors++; $display("FAIL %s_latency: %0d want 168", tag, lat); end
    checks++; if (rsp_data !== 38'h15_DEAD_BEEF) begin errors++;
      $display("FAIL %s_rsp_data: %h want 15deadbeef", tag, rsp_data); end
    checks++; if (model_a !== 38'h2A_5555_AAAA) begin errors++;
      $display("FAIL %s_slave_data: %h want 2a5555aaaa", tag, model_a); end
    checks++; if (n_sdr - s_sdr !== 38) begin errors++; $display("FAIL %s_sdr_count: %0d want 38", tag, n_sdr - s_sdr); end
    checks++; if ({n_uir - s_uir, n_cdr - s_cdr, n_udr - s_udr} !== {32'd1, 32'd1, 32'd1}) begin errors++;
      $display("FAIL %s_uir_cdr_udr: %0d %0d %0d want 1 1 1", tag, n_uir - s_uir, n_cdr - s_cdr, n_udr - s_udr); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL %s_resp_flags: ready=%b busy=%b want 0 1", tag, cmd_ready, busy); end
    consume_a();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL %s_release: valid=%b ready=%b want 0 1", tag, rsp_valid, cmd_ready); end
  endtask

  task automatic test_ir_only;
    int lat, s_uir, s_cdr, s_sdr, s_udr;
    ir_out = 2'b01;
    s_uir = n_uir; s_cdr = n_cdr; s_sdr = n_sdr; s_udr = n_udr;
    run_a(IR_BREAK, 38'h3F_FFFF_FFFF, 1'b1, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ir_only_latency: %0d want 8", lat); end
    checks++; if (rsp_ir_out !== 2'b01 || rsp_data !== '0) begin errors++;
      $display("FAIL ir_only_rsp: irout=%b data=%h want 01 0", rsp_ir_out, rsp_data); end
    checks++; if (n_uir - s_uir !== 1 || uir_ir_a !== 2'b10) begin errors++;
      $display("FAIL ir_only_uir: n=%0d ir_in=%b want 1 10", n_uir - s_uir, uir_ir_a); end
    checks++; if (n_cdr != s_cdr || n_sdr != s_sdr || n_udr != s_udr) begin errors++;
      $display("FAIL ir_only_no_dr: cdr=%0d sdr=%0d udr=%0d want 0 0 0", n_cdr - s_cdr, n_sdr - s_sdr, n_udr - s_udr); end
    consume_a();
    ir_out = 2'b00;
  endtask

  task automatic test_back_to_back;
    int lat;
    load_model_a(38'h00_CAFE_F00D);
    run_a(IR_OCIMEM, 38'h11_2233_4455, 1'b0, lat);
    checks++; if (lat !== 168) begin errors++; $display("FAIL bp_latency: %0d want 168", lat); end
    @(negedge clk);
    cmd_ir = IR_TRACEMEM; cmd_data = 38'h3C_0000_0001; cmd_ir_only = 1'b1; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 38'h00_CAFE_F00D || cmd_ready !== 1'b0) begin errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b want 1 00cafef00d 0", i, rsp_valid, rsp_data, cmd_ready); end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL bp_handoff: valid=%b busy=%b ready=%b want 0 0 1", rsp_valid, busy, cmd_ready); end
    @(posedge clk); #1 cmd_valid = 1'b0;
    checks++; if (busy !== 1'b1 || ir_in !== IR_TRACEMEM) begin errors++;
      $display("FAIL bp_second_accept: busy=%b ir_in=%b want 1 01", busy, ir_in); end
    lat = 0;
    while (!rsp_valid && lat < 1000) begin @(posedge clk); #1 lat++; end
    checks++; if (lat !== 8 || rsp_data !== '0) begin errors++;
      $display("FAIL bp_second_rsp: lat=%0d data=%h want 8 0", lat, rsp_data); end
    consume_a();
  endtask

  task automatic test_reset_mid_sdr;
    int s_sdr, s_udr, waited, seen_valid;
    load_model_a(38'h15_DEAD_BEEF);
    s_sdr = n_sdr;
    @(negedge clk);
    cmd_ir = IR_OCIMEM; cmd_data = 38'h2A_5555_AAAA; cmd_ir_only = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    waited = 0;
    while (n_sdr - s_sdr < 20 && waited < 1000) begin @(posedge clk); #1 waited++; end
    checks++; if (n_sdr - s_sdr !== 20) begin errors++; $display("FAIL abort_reach_bit20: %0d want 20", n_sdr - s_sdr); end
    s_udr = n_udr;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    seen_valid = 0;
    repeat (200) begin @(posedge clk); #1 if (rsp_valid) seen_valid++; end
    checks++; if (n_udr != s_udr || seen_valid != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL abort_quiet: udr=%0d valid_cycles=%0d busy=%b want 0 0 0", n_udr - s_udr, seen_valid, busy); end
    test_full_scan("after_abort");
  endtask

  task automatic test_tck_div1;
    int lat, s_sdr, toggles;
    logic prev;
    preload = 38'h15_DEAD_BEEF; #1 load_b = 1'b1; #1 load_b = 1'b0;
    s_sdr = n_sdr_b;
    @(negedge clk);
    cmd_ir = IR_OCIMEM; cmd_data = 38'h2A_5555_AAAA; cmd_ir_only = 1'b0; cmd_valid_b = 1'b1;
    @(posedge clk); #1 cmd_valid_b = 1'b0;
    lat = 0; toggles = 0; prev = tck_b;
    while (!rsp_valid_b && lat < 1000) begin
      @(posedge clk); #1 lat++;
      if (lat <= 80 && tck_b !== prev) toggles++;
      prev = tck_b;
    end
    checks++; if (lat !== 84) begin errors++; $display("FAIL div1_latency: %0d want 84", lat); end
    checks++; if (toggles !== 80) begin errors++; $display("FAIL div1_tck_toggles: %0d want 80", toggles); end
    checks++; if (rsp_data_b !== 38'h15_DEAD_BEEF || model_b !== 38'h2A_5555_AAAA) begin errors++;
      $display("FAIL div1_data: rsp=%h slave=%h want 15deadbeef 2a5555aaaa", rsp_data_b, model_b); end
    checks++; if (n_sdr_b - s_sdr !== 38) begin errors++; $display("FAIL div1_sdr_count: %0d want 38", n_sdr_b - s_sdr); end
    consume_a();
    checks++; if (rsp_valid_b !== 1'b0 || cmd_ready_b !== 1'b1) begin errors++;
      $display("FAIL div1_release: valid=%b ready=%b want 0 1", rsp_valid_b, cmd_ready_b); end
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_valid_b = 1'b0; rsp_ready = 1'b0;
    cmd_ir = '0; cmd_data = '0; cmd_ir_only = 1'b0; ir_out = '0; preload = '0;
    test_reset();
    test_full_scan("full_scan");
    test_ir_only();
    test_back_to_back();
    test_reset_mid_sdr();
    test_tck_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
